// File: rtl/srl_pkg.sv
// Shared helpers for the SRL-based FIFO slice.
package srl_pkg;

    // Ceiling log2 with a floor of 1, so that vectors are never zero-width.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/srl_fifo_srl_bank.sv
// WIDTH x DEPTH addressable shift register: shifts in at entry 0, reads at A.
module srl_bank
    import srl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                      CLK,
    input  logic                      CE,
    input  logic [clog2(DEPTH)-1:0]   A,
    input  logic [WIDTH-1:0]          D,
    output logic [WIDTH-1:0]          Q
);

    // No reset so the array maps onto SRL primitives; zero at power-up.
    logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

    // Shift the whole chain by one entry on each enabled edge.
    always_ff @(posedge CLK) begin
        if (CE) begin
            mem[0] <= D;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign Q = mem[A];

endmodule

// File: rtl/srl_fifo.sv
// First-word-fall-through FIFO on an addressable shift register,
// with an optional registered output stage (OREG=1 adds one skid entry).
module srl_fifo
    import srl_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int OREG     = 0
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      S_VALID,
    output logic                      S_READY,
    input  logic [WIDTH-1:0]          S_DATA,
    output logic                      M_VALID,
    input  logic                      M_READY,
    output logic [WIDTH-1:0]          M_DATA,
    output logic [clog2(DEPTH+2)-1:0] LEVEL,
    output logic                      ALMOST_FULL
);

    localparam int LVL_W = clog2(DEPTH + 2);
    localparam int CNT_W = clog2(DEPTH + 1);
    localparam int AW    = clog2(DEPTH);
    localparam bit USE_OREG = (OREG != 0);

    if (DEPTH < 2) begin : g_bad_depth
        $error("srl_fifo: DEPTH must be at least 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("srl_fifo: AF_LEVEL must be within 1..DEPTH");
    end

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             oval;
    logic             oval_nxt;
    logic [WIDTH-1:0] odata = '0;
    logic [WIDTH-1:0] q;
    logic [AW-1:0]    rd_addr;
    logic [LVL_W-1:0] lvl_nxt;
    logic             af;
    logic             push;
    logic             pop;
    logic             load;
    logic             ce;

    assign S_READY     = (count != CNT_W'(DEPTH));
    assign M_VALID     = USE_OREG ? oval : (count != '0);
    assign M_DATA      = USE_OREG ? odata : q;
    assign LEVEL       = LVL_W'(count) + LVL_W'(oval);
    assign ALMOST_FULL = af;

    // Pushes presented during reset must not disturb storage.
    assign ce = push && RST_N;

    srl_bank #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_bank (
        .CLK (CLK),
        .CE  (ce),
        .A   (rd_addr),
        .D   (S_DATA),
        .Q   (q)
    );

    // Handshakes, read address and next-state occupancy.
    always_comb begin
        push      = S_VALID && S_READY;
        pop       = 1'b0;
        load      = 1'b0;
        oval_nxt  = 1'b0;
        rd_addr   = (count == '0) ? '0 : AW'(count - CNT_W'(1));
        count_nxt = count;
        if (USE_OREG) begin
            // Head leaves storage when the output register is free or draining.
            load      = (count != '0) && (!oval || M_READY);
            pop       = oval && M_READY;
            oval_nxt  = load ? 1'b1 : (pop ? 1'b0 : oval);
            count_nxt = count + CNT_W'(push) - CNT_W'(load);
        end else begin
            pop       = (count != '0) && M_READY;
            count_nxt = count + CNT_W'(push) - CNT_W'(pop);
        end
        lvl_nxt = LVL_W'(count_nxt) + LVL_W'(oval_nxt);
    end

    // Occupancy, output-valid flag and registered almost-full.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            count <= '0;
            oval  <= 1'b0;
            af    <= 1'b0;
        end else begin
            count <= count_nxt;
            oval  <= oval_nxt;
            af    <= (lvl_nxt >= LVL_W'(AF_LEVEL));
        end
    end

    // Output data register; no reset, only qualified by oval.
    always_ff @(posedge CLK) begin
        if (load) begin
            odata <= q;
        end
    end

    a_count_range: assert property (@(posedge CLK) disable iff (!RST_N)
        count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_srl_fifo.sv
// Scoreboard bench for srl_fifo (OREG=0 and OREG=1 instances).
module tb_srl_fifo;

    localparam int DEPTH = 16;
    localparam int AFL   = 14;

    logic       CLK;
    logic       RST_N;
    logic       S_VALID, M_READY;
    logic [7:0] S_DATA;
    logic       S_READY, M_VALID, ALMOST_FULL;
    logic [7:0] M_DATA;
    logic [4:0] LEVEL;

    logic       o_S_VALID, o_M_READY;
    logic [7:0] o_S_DATA;
    logic       o_S_READY, o_M_VALID, o_ALMOST_FULL;
    logic [7:0] o_M_DATA;
    logic [4:0] o_LEVEL;

    int total = 0;
    int bad   = 0;

    // Reference model of the OREG=0 instance.
    int         mcnt = 0;
    logic [7:0] sb[$];
    logic [7:0] osb[$];
    logic       popped;
    logic [7:0] obs_data, exp_data;
    logic       o_popped;
    logic [7:0] o_obs;

    srl_fifo #(.WIDTH(8), .DEPTH(DEPTH), .AF_LEVEL(AFL), .OREG(0)) u_dut (
        .CLK(CLK), .RST_N(RST_N),
        .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
        .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA),
        .LEVEL(LEVEL), .ALMOST_FULL(ALMOST_FULL)
    );

    srl_fifo #(.WIDTH(8), .DEPTH(DEPTH), .AF_LEVEL(AFL), .OREG(1)) u_oreg (
        .CLK(CLK), .RST_N(RST_N),
        .S_VALID(o_S_VALID), .S_READY(o_S_READY), .S_DATA(o_S_DATA),
        .M_VALID(o_M_VALID), .M_READY(o_M_READY), .M_DATA(o_M_DATA),
        .LEVEL(o_LEVEL), .ALMOST_FULL(o_ALMOST_FULL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One cycle on the OREG=0 instance; model decides the handshakes.
    task automatic cyc(input logic sv, input logic [7:0] sd, input logic mr, input logic rst);
        logic pushed;
        S_VALID = sv; S_DATA = sd; M_READY = mr; RST_N = !rst;
        #1;
        pushed   = sv && (mcnt < DEPTH) && !rst;
        popped   = mr && (mcnt > 0) && !rst;
        obs_data = M_DATA;
        exp_data = 8'h00;
        if (popped) exp_data = sb.pop_front();
        if (rst) begin
            sb.delete();
            mcnt = 0;
        end else begin
            if (pushed) sb.push_back(sd);
            mcnt = mcnt + int'(pushed) - int'(popped);
        end
        @(posedge CLK); #1;
    endtask

    // One cycle on the OREG=1 instance.
    task automatic ocyc(input logic sv, input logic [7:0] sd, input logic mr);
        o_S_VALID = sv; o_S_DATA = sd; o_M_READY = mr;
        #1;
        o_popped = o_M_VALID && mr;
        o_obs    = o_M_DATA;
        if (sv && o_S_READY) osb.push_back(sd);
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        cyc(0, 8'h00, 0, 1);
        cyc(0, 8'h00, 0, 1);
        total++; if (LEVEL !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", LEVEL); end
        total++; if (M_VALID !== 1'b0) begin bad++; $display("FAIL reset_mvalid got=%b want=0", M_VALID); end
        total++; if (S_READY !== 1'b1) begin bad++; $display("FAIL reset_sready got=%b want=1", S_READY); end
        total++; if (ALMOST_FULL !== 1'b0) begin bad++; $display("FAIL reset_af got=%b want=0", ALMOST_FULL); end
        total++; if (o_M_VALID !== 1'b0 || o_LEVEL !== 5'd0) begin bad++; $display("FAIL reset_oreg got=%b/%0d want=0/0", o_M_VALID, o_LEVEL); end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && mcnt > 0; i++) begin
            cyc(0, 8'h00, 1, 0);
            total++; if (obs_data !== exp_data) begin bad++; $display("FAIL %s_data got=%h want=%h", tag, obs_data, exp_data); end
        end
        total++; if (M_VALID !== 1'b0 || LEVEL !== 5'd0) begin bad++; $display("FAIL %s_empty got=%b/%0d want=0/0", tag, M_VALID, LEVEL); end
    endtask

    task automatic test_basic();
        logic [7:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) cyc(1, d[i], 0, 0);
        total++; if (LEVEL !== 5'd4) begin bad++; $display("FAIL basic_level got=%0d want=4", LEVEL); end
        total++; if (M_VALID !== 1'b1) begin bad++; $display("FAIL basic_mvalid got=%b want=1", M_VALID); end
        total++; if (M_DATA !== 8'h11) begin bad++; $display("FAIL basic_head got=%h want=11", M_DATA); end
        total++; if (S_READY !== 1'b1) begin bad++; $display("FAIL basic_sready got=%b want=1", S_READY); end
        drain("basic");
        // Pop request on an empty FIFO must not underflow.
        cyc(0, 8'h00, 1, 0);
        total++; if (LEVEL !== 5'd0) begin bad++; $display("FAIL empty_pop_level got=%0d want=0", LEVEL); end
    endtask

    task automatic test_full_af();
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1, 8'(i), 0, 0);
            total++; if (S_READY !== (mcnt < DEPTH)) begin bad++; $display("FAIL fill_sready n=%0d got=%b", mcnt, S_READY); end
            total++; if (ALMOST_FULL !== (mcnt >= AFL)) begin bad++; $display("FAIL fill_af n=%0d got=%b want=%b", mcnt, ALMOST_FULL, mcnt >= AFL); end
        end
        cyc(1, 8'hAA, 0, 0);
        total++; if (LEVEL !== 5'd16) begin bad++; $display("FAIL full_drop_level got=%0d want=16", LEVEL); end
        // Pop while full: the write offered alongside must be refused.
        cyc(1, 8'hBB, 1, 0);
        total++; if (obs_data !== exp_data) begin bad++; $display("FAIL full_pop_data got=%h want=%h", obs_data, exp_data); end
        total++; if (LEVEL !== 5'd15) begin bad++; $display("FAIL full_pop_level got=%0d want=15", LEVEL); end
        for (int i = 0; i < 2; i++) begin
            cyc(0, 8'h00, 1, 0);
            total++; if (obs_data !== exp_data) begin bad++; $display("FAIL af_drain_data got=%h want=%h", obs_data, exp_data); end
            total++; if (ALMOST_FULL !== (mcnt >= AFL)) begin bad++; $display("FAIL af_drop n=%0d got=%b", mcnt, ALMOST_FULL); end
        end
        drain("full");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'h80 + i), 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 8'(8'h85 + i), 1, 0);
            total++; if (obs_data !== exp_data) begin bad++; $display("FAIL b2b_data i=%0d got=%h want=%h", i, obs_data, exp_data); end
            total++; if (LEVEL !== 5'd5) begin bad++; $display("FAIL b2b_level i=%0d got=%0d want=5", i, LEVEL); end
        end
        drain("b2b");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) cyc(1, 8'(8'h40 + i), 0, 0);
        cyc(1, 8'hEE, 1, 1);
        total++; if (LEVEL !== 5'd0 || M_VALID !== 1'b0 || S_READY !== 1'b1) begin
            bad++; $display("FAIL midrst got=%0d/%b/%b want=0/0/1", LEVEL, M_VALID, S_READY); end
        cyc(1, 8'h5A, 0, 0);
        total++; if (M_VALID !== 1'b1 || M_DATA !== 8'h5A) begin bad++; $display("FAIL midrst_push got=%b/%h want=1/5a", M_VALID, M_DATA); end
        drain("midrst");
    endtask

    task automatic test_oreg();
        logic [7:0] e;
        ocyc(1, 8'h3C, 0);
        total++; if (o_M_VALID !== 1'b0) begin bad++; $display("FAIL oreg_lat1 got=%b want=0", o_M_VALID); end
        ocyc(0, 8'h00, 0);
        total++; if (o_M_VALID !== 1'b1 || o_M_DATA !== 8'h3C) begin bad++; $display("FAIL oreg_lat2 got=%b/%h want=1/3c", o_M_VALID, o_M_DATA); end
        total++; if (o_LEVEL !== 5'd1) begin bad++; $display("FAIL oreg_level1 got=%0d want=1", o_LEVEL); end
        ocyc(0, 8'h00, 1);
        void'(osb.pop_front());
        total++; if (o_M_VALID !== 1'b0 || o_LEVEL !== 5'd0) begin bad++; $display("FAIL oreg_pop got=%b/%0d want=0/0", o_M_VALID, o_LEVEL); end
        for (int i = 0; i < DEPTH + 1; i++) begin
            ocyc(1, 8'(8'hC0 + i), 0);
            total++; if (o_LEVEL !== 5'(i + 1)) begin bad++; $display("FAIL oreg_fill_level i=%0d got=%0d want=%0d", i, o_LEVEL, i + 1); end
            total++; if (o_S_READY !== (i + 1 < DEPTH + 1)) begin bad++; $display("FAIL oreg_fill_sready i=%0d got=%b", i, o_S_READY); end
        end
        ocyc(1, 8'hAA, 0);
        total++; if (o_LEVEL !== 5'd17) begin bad++; $display("FAIL oreg_drop got=%0d want=17", o_LEVEL); end
        for (int i = 0; i < 40 && osb.size() > 0; i++) begin
            ocyc(0, 8'h00, 1);
            if (o_popped) begin
                e = osb.pop_front();
                total++; if (o_obs !== e) begin bad++; $display("FAIL oreg_data got=%h want=%h", o_obs, e); end
            end
        end
        total++; if (osb.size() != 0 || o_M_VALID !== 1'b0 || o_LEVEL !== 5'd0) begin
            bad++; $display("FAIL oreg_drain left=%0d got=%b/%0d want=0/0", osb.size(), o_M_VALID, o_LEVEL); end
    endtask

    initial begin
        RST_N = 1'b0; S_VALID = 1'b0; S_DATA = '0; M_READY = 1'b0;
        o_S_VALID = 1'b0; o_S_DATA = '0; o_M_READY = 1'b0;
        @(posedge CLK); #1;
        test_reset();
        test_basic();
        test_full_af();
        test_back_to_back();
        test_reset_mid();
        test_oreg();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/srl_fifo.md
Name: srl_fifo

Overview:
- Parametrised first-word-fall-through FIFO built on an addressable shift register.
- This block is the generalised successor of the 32-deep, 1-bit addressable shift-register primitive: width and depth are parametrised, and it adds occupancy tracking with valid/ready handshakes on both sides.
- It serves as the small elastic buffer (clock-domain-local) between pipeline stages in the simulation models and the synthesizable glue.
- Storage maps directly onto SRL resources: data always shifts in at position 0 and is read from position (count-1).

Parameters:
- WIDTH, 8, data bits per entry (1..256).
- DEPTH, 16, number of entries (2..256; need not be a power of two).
- AF_LEVEL, DEPTH-2, ALMOST_FULL asserts when level >= AF_LEVEL (1..DEPTH).
- OREG, 0, 0 = combinational M_DATA from storage; 1 = registered output stage (adds one skid entry, total capacity DEPTH+1).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  synchronous active-low reset.
- S_VALID  in  1  write-side data valid.
- S_READY  out  1  write-side ready (not full).
- S_DATA  in  WIDTH  write data.
- M_VALID  out  1  read-side data valid (not empty).
- M_READY  in  1  read-side consumer ready.
- M_DATA  out  WIDTH  read data (head of queue).
- LEVEL  out  clog2(DEPTH+2)  current occupancy, including the output register when OREG=1.
- ALMOST_FULL  out  1  LEVEL >= AF_LEVEL.

Behaviour:
- Reset, sampled on a CLK rise with RST_N=0:
  - count=0, LEVEL=0, M_VALID=0, S_READY=1, ALMOST_FULL=0.
  - Output register valid flag cleared.
  - Shift storage is NOT reset, to keep SRL inference; its power-up value is all zeros.
  - M_DATA is don't-care while M_VALID=0.
- Push: S_VALID & S_READY. Storage shifts by one: entry[i] <= entry[i-1], entry[0] <= S_DATA.
- Pop: M_VALID & M_READY.
- OREG=0:
  - M_DATA = entry[count-1] combinationally; the address is 0 when count=0.
  - M_VALID = (count != 0); S_READY = (count != DEPTH).
  - Push only: count+1. Pop only: count-1. Push and pop together: count unchanged. The shift moves the head from entry[count-1] to entry[count], so the read address stays valid after the shift. Zero-cycle latency after write is NOT provided: data written in cycle n is visible on M_DATA from cycle n+1.
- Full: S_READY=0, so writes are back-pressured. Simultaneous pop while full does not enable a write in the same cycle (S_READY depends only on count; there is no combinational path from M_READY to S_READY).
- Empty: M_VALID=0. M_READY is ignored and count does not underflow.
- OREG=1:
  - The output register (oval, odata) drives M_VALID/M_DATA.
  - oval/odata load from entry[count-1] when (!oval | M_READY) and count != 0; count decrements on that load.
  - Pass-through latency: write in cycle n gives M_VALID at cycle n+2.
  - LEVEL = count + oval.
- Widths:
  - count is clog2(DEPTH+1) bits and never wraps. The implementation carries an assertion: count <= DEPTH.
  - LEVEL saturates by construction; ALMOST_FULL is registered from next-state LEVEL, so it has no combinational path from the inputs.
- Reset mid-operation:
  - All queued entries are discarded on that edge, and M_VALID drops in the following cycle.
  - Any push or pop presented in the reset cycle is ignored.
- No X propagation on M_DATA when empty, because storage is zero-initialised.

Decomposition:
- Shared package srl_pkg:
  - clog2 function.
  - localparams LVL_W = clog2(DEPTH+2) and CNT_W = clog2(DEPTH+1), computed in-module via the package function.
  - Parameter-legality checks (DEPTH>=2, 1<=AF_LEVEL<=DEPTH) as elaboration-time assertions.
- One sub-module srl_bank:
  - WIDTH x DEPTH addressable shift register with ports CLK, CE, A[clog2(DEPTH)-1:0], D[WIDTH-1:0], Q[WIDTH-1:0].
  - No reset; zero-initialised.
  - It is the generalised SRL storage. srl_fifo holds only the count, flags and the optional output register.

Test Plan:
- Reset then 4 pushes 0x11,0x22,0x33,0x44 with M_READY=0 -> LEVEL=4, M_VALID=1, M_DATA=0x11, S_READY=1.
- DEPTH=16: push 16 words 0x00..0x0F with M_READY=0 -> S_READY=0 after 16th, 17th write (0xAA) dropped. Drain -> 0x00..0x0F in order, then M_VALID=0, LEVEL=0.
- Hold LEVEL=5, S_VALID=M_READY=1 for 20 cycles with incrementing data -> LEVEL stays 5, output sequence strictly in order with no gap or duplicate.
- AF_LEVEL=14: fill to 13 -> ALMOST_FULL=0. 14th push -> ALMOST_FULL=1 the next cycle. One pop -> 0.
- Fill to 7, assert RST_N=0 for one cycle with S_VALID=M_READY=1 -> next cycle LEVEL=0, M_VALID=0, S_READY=1. The next push (0x5A) appears as M_DATA=0x5A.
- OREG=1: a single push 0x3C at cycle n -> M_VALID rises at n+2 with M_DATA=0x3C. Full capacity = DEPTH+1 entries before S_READY=0.
